// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial pattern generator: FSM states and the
// default frame pattern also used by the sequence detector bench.
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [3:0] SEQ_PATTERN_DEFAULT = 4'b1110;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; zeros shift in from the LSB so the
// register drains to all-zero after the last pattern bit leaves.
module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  output logic             msb
);

  logic [PAT_W-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= pattern;
    end else if (shift) begin
      sh_q <= {sh_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = sh_q[PAT_W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: repeats PATTERN MSB-first a latched number of
// times with zero-filled gaps; all outputs come straight from flops.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN_DEFAULT,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             X,
  output logic             valid,
  output logic             frame_sync,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W    = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  seq_state_e       state, state_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] frm_cnt, frm_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [GAP_W-1:0] gap_len_q;
  logic             load, shift, latch;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    frm_cnt_n = frm_cnt;
    gap_cnt_n = gap_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (repeat_cnt != '0) begin
            state_n   = SEND;
            load      = 1'b1;
            latch     = 1'b1;
            frm_cnt_n = repeat_cnt;
            bit_cnt_n = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      SEND: begin
        shift = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          frm_cnt_n = frm_cnt - CNT_W'(1);
          bit_cnt_n = '0;
          if (frm_cnt == CNT_W'(1)) begin
            state_n = DONE;
          end else if (gap_len_q == '0) begin
            load = 1'b1;
          end else begin
            state_n   = GAP;
            gap_cnt_n = gap_len_q;
          end
        end else begin
          bit_cnt_n = bit_cnt + BIT_W'(1);
        end
      end
      GAP: begin
        // gap counter runs down from gap_len; the last zero cycle is at 1
        if (gap_cnt == GAP_W'(1)) begin
          state_n   = SEND;
          load      = 1'b1;
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with X.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      frm_cnt    <= '0;
      gap_cnt    <= '0;
      gap_len_q  <= '0;
      valid      <= 1'b0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      frm_cnt    <= frm_cnt_n;
      gap_cnt    <= gap_cnt_n;
      if (latch) gap_len_q <= gap_len;
      valid      <= (state_n == SEND);
      frame_sync <= load;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
    end
  end

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk     (clk),
    .clr     (rst),
    .load    (load),
    .shift   (shift),
    .pattern (PATTERN),
    .msb     (X)
  );

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a 1110 loopback detector model.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       X, valid, frame_sync, busy, done;

  int checks = 0;
  int errors = 0;

  logic [3:0]  hist = 4'b0;
  int          det_cnt = 0;
  int          det_base;
  logic [63:0] obs_bits;
  logic [15:0] exp16;
  logic [7:0]  exp8;
  logic [3:0]  pat = 4'b1110;

  sequence_generator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .X          (X),
    .valid      (valid),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference 1110 detector fed by the serial line.
  always @(posedge clk) begin
    hist <= {hist[2:0], X};
    if ({hist[2:0], X} == 4'b1110) det_cnt <= det_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ex, input logic ev,
                     input logic efs, input logic eb, input logic ed);
    logic [4:0] o, e;
    o = {X, valid, frame_sync, busy, done};
    e = {ex, ev, efs, eb, ed};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0t {X,valid,fs,busy,done} observed=%b expected=%b", tag, $time, o, e);
    end
  endtask

  task automatic chk_val(input string tag, input longint o, input longint e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Full burst from IDLE; with noise, start is held high (with other params)
  // through the burst and the done cycle, and must have no effect.
  task automatic run_burst(input string tag, input int rc, input int gl,
                           input bit noise, output logic [63:0] obs);
    obs        = '0;
    repeat_cnt = 8'(rc);
    gap_len    = 4'(gl);
    start      = 1'b1;
    step();
    start = noise;
    if (noise) begin
      repeat_cnt = 8'd7;
      gap_len    = 4'd5;
    end
    for (int f = 0; f < rc; f++) begin
      for (int b = 0; b < 4; b++) begin
        chk(tag, pat[3-b], 1'b1, (b == 0), 1'b1, 1'b0);
        obs = {obs[62:0], X};
        step();
      end
      if (f < rc - 1) begin
        for (int g = 0; g < gl; g++) begin
          chk(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          obs = {obs[62:0], X};
          step();
        end
      end
    end
    chk({tag, "_done"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    start = 1'b0;
    chk({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    repeat_cnt = 8'd0;
    gap_len    = 4'd0;
    step();
    step();
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3 frames, gap 2
    det_base = det_cnt;
    run_burst("b3g2", 3, 2, 1'b0, obs_bits);
    exp16 = 16'b1110001110001110;
    chk_val("b3g2_bits", obs_bits[15:0], exp16);
    chk_val("b3g2_loopback", det_cnt - det_base, 3);

    // back-to-back frames
    det_base = det_cnt;
    run_burst("b2g0", 2, 0, 1'b0, obs_bits);
    exp8 = 8'b11101110;
    chk_val("b2g0_bits", obs_bits[7:0], exp8);
    chk_val("b2g0_loopback", det_cnt - det_base, 2);

    // zero-frame burst
    run_burst("b0", 0, 3, 1'b0, obs_bits);

    // single frame, one-cycle gap setting unused
    run_burst("b1g1", 1, 1, 1'b0, obs_bits);

    // reset at bit 2 of the second frame
    repeat_cnt = 8'd3;
    gap_len    = 4'd2;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("rst_f0", pat[3-b], 1'b1, (b == 0), 1'b1, 1'b0);
      step();
    end
    for (int g = 0; g < 2; g++) begin
      chk("rst_gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    for (int b = 0; b < 3; b++) begin
      chk("rst_f1", pat[3-b], 1'b1, (b == 0), 1'b1, 1'b0);
      if (b < 2) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // clean burst after abort
    det_base = det_cnt;
    run_burst("after_rst", 3, 2, 1'b0, obs_bits);
    chk_val("after_rst_bits", obs_bits[15:0], exp16);
    chk_val("after_rst_loopback", det_cnt - det_base, 3);

    // start held high throughout the burst and the done cycle
    run_burst("noise", 3, 2, 1'b1, obs_bits);
    chk_val("noise_bits", obs_bits[15:0], exp16);
    step();
    chk("noise_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start coincident with rst
    repeat_cnt = 8'd2;
    gap_len    = 4'd1;
    rst        = 1'b1;
    start      = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_start_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // earliest restart: first IDLE cycle after done
    run_burst("restart_a", 1, 0, 1'b0, obs_bits);
    run_burst("restart_b", 2, 3, 1'b0, obs_bits);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter that emits a fixed bit pattern, MSB first, one bit per clock, repeated a programmable number of times with programmable zero-filled gaps between frames. It is the driving end of the single-bit serial line consumed by the team's sequence detector: its `X` output connects directly to the detector's `X` input. Benches and system-level stimulus use it in place of hand-written bit sequences.

## Interface
- `PAT_W`, 4: pattern length in bits (≥ 2).
- `PATTERN`, 4'b1110: pattern transmitted, MSB first.
- `CNT_W`, 8: width of the frame-repeat count.
- `GAP_W`, 4: width of the inter-frame gap length.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a burst; sampled only in IDLE.
- `repeat_cnt` in CNT_W: number of frames in the burst; latched on accepted `start`.
- `gap_len` in GAP_W: number of zero bits between consecutive frames; latched on accepted `start`.
- `X` out 1: serial data; 0 whenever not sending a pattern bit.
- `valid` out 1: high while `X` carries a pattern bit.
- `frame_sync` out 1: high on the first (MSB) bit of each frame.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle after `done`.
- `done` out 1: one-cycle pulse after the last bit of the burst.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: outputs 0. `start`=1 with `repeat_cnt`≠0: latch `repeat_cnt` and `gap_len`, load the shift register with `PATTERN`, go to SEND. `start`=1 with `repeat_cnt`=0: go directly to DONE without sending any bits.
- SEND: `X` = current MSB, `valid`=1, bit counter increments each cycle. After bit `PAT_W-1`: decrement the remaining-frame count. If 0 frames remain, go to DONE. If frames remain and gap=0, reload `PATTERN` and stay in SEND (back-to-back frames). Otherwise go to GAP.
- GAP: `X`=0, `valid`=0 for exactly `gap_len` cycles; then reload `PATTERN` and go to SEND.
- DONE: `done`=1 for one cycle, `X`=0; then go to IDLE.
- `start` outside IDLE is ignored; latched parameters do not change mid-burst.
- All outputs are registered. Reset values: `X`=0, `valid`=0, `frame_sync`=0, `busy`=0, `done`=0; state=IDLE; all counters 0.
- Counter widths: frame counter CNT_W, gap counter GAP_W, bit counter $clog2(PAT_W); no wrap occurs within legal operation.

## Timing
- `start` sampled at edge N; first pattern bit appears on `X` after edge N+1, so it is visible during cycle N+1.
- Burst length is `repeat_cnt`·PAT_W + (`repeat_cnt`−1)·`gap_len` cycles. `done` is asserted in the cycle immediately after the last bit.
- `repeat_cnt`=0: `done` is asserted in cycle N+1, with `valid` never high.
- `busy` is asserted from cycle N+1 through the `done` cycle inclusive.
- `rst` mid-burst: at the next edge all outputs are 0 and the state is IDLE, and `done` is not pulsed. `rst` and `start` in the same cycle: `rst` wins.
- `start` in the `done` cycle is ignored. The earliest accepted restart is in the first IDLE cycle.

## Structure
- Package `seqgen_pkg`: state enum (IDLE/SEND/GAP/DONE) and default-pattern constant `SEQ_PATTERN_DEFAULT` = 4'b1110, shared with the detector bench.
- One natural sub-module, `seq_piso`: a PAT_W parallel-load, MSB-first shift register with `load` and `shift` controls. The FSM and counters live in the top module.

## Test plan
- Defaults, `repeat_cnt`=3, `gap_len`=2, `start` at cycle 2 -> `X` = 1110 00 1110 00 1110 in cycles 3–18, with `valid` high only on pattern bits and `frame_sync` high in cycles 3, 9 and 15. `done` is high in cycle 19, and `busy` is high in cycles 3–19.
- `repeat_cnt`=2, `gap_len`=0 -> `X` = 11101110 back-to-back, `frame_sync` high on bits 0 and 4, `done` asserted 9 cycles after `start`.
- `repeat_cnt`=0 -> `done` pulses in the cycle after `start`, with `valid` and `X` held at 0.
- `rst` asserted at bit 2 of the second frame -> `X`/`valid`/`busy` are 0 at the next edge, with no `done` pulse. A subsequent `start` produces a clean full burst.
- `start` re-pulsed while `busy`, and `start` coincident with `rst` -> both are ignored, and burst length and output are unchanged.
- Loopback: `X` feeds the sequence detector configured for 1110 -> the detector's `Y` fires once per frame, three times for the first scenario.
